// File: rtl/cop0_exc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : cop0_exc_ctrl
//  Brief    : Coprocessor-0 register file with exception/interrupt control.
//  Revision : 1.0  initial release
// ============================================================================
module cop0_exc_ctrl #(
   parameter int          NUM_EXC    = 6,
   parameter int          NUM_IRQ    = 5,
   parameter logic [31:0] KERNEL_VEC = 32'h80000180,
   parameter int          RANDOM_LO  = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 wen,
   input  logic [4:0]           wreg,
   input  logic [31:0]          wdata,
   input  logic [4:0]           rreg,
   output logic [31:0]          rdata,
   input  logic [NUM_EXC-1:0]   exc_req,
   input  logic [5*NUM_EXC-1:0] exc_code,
   input  logic [NUM_IRQ-1:0]   irq,
   input  logic [31:0]          epc_in,
   input  logic [31:0]          badvaddr_in,
   input  logic                 eret,
   output logic                 flush,
   output logic [31:0]          redirect_pc,
   output logic                 user_mode,
   output logic                 exc_level,
   output logic [31:0]          epc_out,
   output logic                 timer_irq
);

   localparam logic [4:0] c_REG_RANDOM   = 5'd1;
   localparam logic [4:0] c_REG_BADVADDR = 5'd8;
   localparam logic [4:0] c_REG_COUNT    = 5'd9;
   localparam logic [4:0] c_REG_COMPARE  = 5'd11;
   localparam logic [4:0] c_REG_STATUS   = 5'd12;
   localparam logic [4:0] c_REG_CAUSE    = 5'd13;
   localparam logic [4:0] c_REG_EPC      = 5'd14;
   localparam logic [4:0] c_RANDOM_LO    = 5'(RANDOM_LO);
   localparam logic [4:0] c_RANDOM_HI    = 5'd31;

   logic        r_ie, r_exl, r_um;
   logic [7:0]  r_im;
   logic [4:0]  r_exc_code;
   logic [7:0]  r_ip;
   logic [31:0] r_epc, r_badvaddr, r_count, r_compare;
   logic [4:0]  r_random;
   logic        r_flush;
   logic [31:0] r_redirect_pc;

   logic        w_wr_status, w_wr_cause, w_wr_epc, w_wr_count, w_wr_compare;
   logic        w_sync;
   logic [4:0]  w_sync_code;
   logic        w_pending, w_take, w_do_eret;
   logic [4:0]  w_take_code;
   logic [4:0]  w_ext_ip;

   assign w_wr_status  = wen && (wreg == c_REG_STATUS);
   assign w_wr_cause   = wen && (wreg == c_REG_CAUSE);
   assign w_wr_epc     = wen && (wreg == c_REG_EPC);
   assign w_wr_count   = wen && (wreg == c_REG_COUNT);
   assign w_wr_compare = wen && (wreg == c_REG_COMPARE);

   // Scan from the lowest priority upward so the lowest set index lands last.
   always_comb begin
      w_sync      = 1'b0;
      w_sync_code = 5'd0;
      for (int i = NUM_EXC - 1; i >= 0; i--) begin
         if (exc_req[i]) begin
            w_sync      = 1'b1;
            w_sync_code = exc_code[5*i +: 5];
         end
      end
   end

   always_comb begin
      w_ext_ip              = 5'd0;
      w_ext_ip[NUM_IRQ-1:0] = irq;
   end

   assign w_pending   = r_ie & ~r_exl & (|(r_ip & r_im));
   assign w_take      = w_sync | w_pending;
   assign w_take_code = w_sync ? w_sync_code : 5'd0;
   assign w_do_eret   = eret & ~w_take;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ie          <= 1'b0;
         r_exl         <= 1'b0;
         r_um          <= 1'b0;
         r_im          <= 8'd0;
         r_exc_code    <= 5'd0;
         r_ip          <= 8'd0;
         r_epc         <= 32'd0;
         r_badvaddr    <= 32'd0;
         r_count       <= 32'd0;
         r_compare     <= 32'd0;
         r_random      <= c_RANDOM_HI;
         r_flush       <= 1'b0;
         r_redirect_pc <= 32'd0;
      end else begin
         if (w_wr_status) begin
            r_ie  <= wdata[0];
            r_exl <= wdata[1];
            r_um  <= wdata[4];
            r_im  <= wdata[15:8];
         end
         // A take or eret overrides whatever EXL the mtc0 carried.
         if (w_take)
            r_exl <= 1'b1;
         else if (w_do_eret)
            r_exl <= 1'b0;

         if (w_take)
            r_exc_code <= w_take_code;

         if (w_wr_cause)
            r_ip[1:0] <= wdata[9:8];
         r_ip[6:2] <= w_ext_ip;
         if (w_wr_compare)
            r_ip[7] <= 1'b0;
         else if (r_count == r_compare)
            r_ip[7] <= 1'b1;

         if (w_take) begin
            if (!r_exl)
               r_epc <= epc_in;
         end else if (w_wr_epc) begin
            r_epc <= wdata;
         end

         if (w_take && (w_take_code == 5'd4 || w_take_code == 5'd5))
            r_badvaddr <= badvaddr_in;

         r_count <= w_wr_count ? wdata : r_count + 32'd1;
         if (w_wr_compare)
            r_compare <= wdata;

         r_random <= (r_random == c_RANDOM_LO) ? c_RANDOM_HI : r_random - 5'd1;

         r_flush <= w_take | w_do_eret;
         if (w_take)
            r_redirect_pc <= KERNEL_VEC;
         else if (w_do_eret)
            r_redirect_pc <= r_epc;
      end
   end

   always_comb begin
      rdata = 32'd0;
      if (!reset) begin
         case (rreg)
            c_REG_RANDOM:   rdata = {27'd0, r_random};
            c_REG_BADVADDR: rdata = r_badvaddr;
            c_REG_COUNT:    rdata = r_count;
            c_REG_COMPARE:  rdata = r_compare;
            c_REG_STATUS:   rdata = {16'd0, r_im, 3'd0, r_um, 2'd0, r_exl, r_ie};
            c_REG_CAUSE:    rdata = {16'd0, r_ip, 1'b0, r_exc_code, 2'd0};
            c_REG_EPC:      rdata = r_epc;
            default:        rdata = 32'd0;
         endcase
      end
   end

   assign flush       = r_flush;
   assign redirect_pc = r_redirect_pc;
   assign user_mode   = r_um & ~r_exl;
   assign exc_level   = r_exl;
   assign epc_out     = r_epc;
   assign timer_irq   = r_ip[7];

endmodule
`default_nettype wire
